// File: rtl/sipo7_pkg.sv
// Shared types and defaults for the sipo7 deserializer slice.
package sipo7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int SIPO7_DEFAULT_WIDTH = 7;

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts accepted data bits and flags a full word.
module sipo_bit_counter
    import sipo7_pkg::*;
#(
    parameter int WIDTH = SIPO7_DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == CW'(WIDTH));

endmodule

// File: rtl/sipo7_deser.sv
// Framed serial-in/parallel-out deserializer with valid/ready output hold.
// Optional even-parity check enabled by defining SIPO7_PARITY_CHECK_EN.
module sipo7_deser
    import sipo7_pkg::*;
#(
    parameter int WIDTH     = SIPO7_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    count;
    logic             done;
    logic             accept;
    logic             take_bit;
    logic             last_bit;
    logic             cnt_clr;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (LSB_FIRST) begin
            return {b, cur[WIDTH-1:1]};
        end else begin
            return {cur[WIDTH-2:0], b};
        end
    endfunction

    assign accept   = word_valid && word_ready;
    // start wins over a same-cycle bit; done guards against counting past a full word
    assign take_bit = (state == SHIFT) && bit_valid && !start && !done;
    assign last_bit = take_bit && (count == CW'(WIDTH - 1));
    assign cnt_clr  = start && ((state != HOLD) || accept);
    assign sr_next  = shift_in(sr, bit_in);

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clr),
        .inc   (take_bit),
        .count (count),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            sr <= '0;
        end else if (take_bit) begin
            sr <= sr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_out   <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO7_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!start && last_bit) begin
`ifdef SIPO7_PARITY_CHECK_EN
                        state <= PARITY;
`else
                        state      <= HOLD;
                        busy       <= 1'b0;
                        word_valid <= 1'b1;
                        word_out   <= sr_next;
`endif
                    end
                end
`ifdef SIPO7_PARITY_CHECK_EN
                PARITY: begin
                    if (start) begin
                        state <= SHIFT;
                    end else if (bit_valid) begin
                        state      <= HOLD;
                        busy       <= 1'b0;
                        word_valid <= 1'b1;
                        word_out   <= sr;
                        parity_err <= ^{sr, bit_in};
                    end
                end
`endif
                HOLD: begin
                    if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                    if (word_ready) begin
                        word_valid <= 1'b0;
`ifdef SIPO7_PARITY_CHECK_EN
                        parity_err <= 1'b0;
`endif
                        if (start) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SIPO7_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule
